// File: rtl/xbar_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module : xbar_cfg_pkg
// Brief  : Shared types and SPI message layout for the crossbar config arbiter
// Rev    : 1.0  initial release
// ============================================================================
package xbar_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WB_ACK   = 2'd1,
    SPI_RESP = 2'd2
  } state_e;

  typedef enum logic {
    REQ_WB  = 1'b0,
    REQ_SPI = 1'b1
  } req_e;

  localparam int XBAR_IDX_INPUT      = 0;
  localparam int XBAR_IDX_CLASSIFIER = 1;
  localparam int XBAR_IDX_OUTPUT     = 2;

  localparam int SPI_DATA_LSB = 0;
  localparam int SPI_IDX_W    = 2;

  // SPI message is {we, index[1:0], data[SEL_BITS-1:0]}
  function automatic int spi_idx_lsb(input int sel_bits);
    return sel_bits;
  endfunction

  function automatic int spi_we_bit(input int sel_bits);
    return sel_bits + SPI_IDX_W;
  endfunction

  function automatic int spi_msg_w(input int sel_bits);
    return sel_bits + SPI_IDX_W + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xbar_cfg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : xbar_cfg_arbiter_if
// Brief  : Wishbone slave and SPI val/rdy request/response bundle
// Rev    : 1.0  initial release
// ============================================================================
interface xbar_cfg_arbiter_if #(
  parameter int SEL_BITS = 4
);
  logic                wbs_stb_i;
  logic                wbs_cyc_i;
  logic                wbs_we_i;
  logic [3:0]          wbs_sel_i;
  logic [31:0]         wbs_adr_i;
  logic [31:0]         wbs_dat_i;
  logic                wbs_ack_o;
  logic [31:0]         wbs_dat_o;
  logic                spi_req_val;
  logic                spi_req_rdy;
  logic [SEL_BITS+2:0] spi_req_msg;
  logic                spi_resp_val;
  logic                spi_resp_rdy;
  logic [SEL_BITS-1:0] spi_resp_msg;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output spi_req_val, spi_req_msg, spi_resp_rdy,
    input  spi_req_rdy, spi_resp_val, spi_resp_msg
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  spi_req_val, spi_req_msg, spi_resp_rdy,
    output spi_req_rdy, spi_resp_val, spi_resp_msg
  );
endinterface
`default_nettype wire

// File: rtl/xbar_cfg_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter2
// Brief  : Two-input round-robin arbiter (WB vs SPI) with grant enable
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import xbar_cfg_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic req_wb,
  input  wire logic req_spi,
  input  wire logic en,
  output logic      gnt_wb,
  output logic      gnt_spi
);

  logic r_last;

  // On a tie the requester that did not win last time is served
  assign gnt_wb  = en & req_wb  & (~req_spi | (r_last == REQ_SPI));
  assign gnt_spi = en & req_spi & (~req_wb  | (r_last == REQ_WB));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= REQ_SPI;
    end else if (gnt_wb) begin
      r_last <= REQ_WB;
    end else if (gnt_spi) begin
      r_last <= REQ_SPI;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xbar_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module : xbar_cfg_arbiter
// Brief  : Crossbar select registers shared between Wishbone and SPI access.
//          Optional macro XBAR_CFG_PARITY_EN adds cfg_parity_o.
// Rev    : 1.0  initial release
// ============================================================================
module xbar_cfg_arbiter
  import xbar_cfg_pkg::*;
#(
  parameter int          NUM_XBARS = 3,
  parameter int          SEL_BITS  = 4,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  xbar_cfg_arbiter_if.slave                  bus,
  input  wire logic [NUM_XBARS-1:0]          override_i,
  output logic      [NUM_XBARS*SEL_BITS-1:0] cfg_sel_o,
  output logic      [NUM_XBARS-1:0]          cfg_update_o
`ifdef XBAR_CFG_PARITY_EN
  ,
  output logic                               cfg_parity_o
`endif
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_WB_ACK   = WB_ACK;
  localparam logic [1:0] S_SPI_RESP = SPI_RESP;
  localparam int         IDX_LSB    = spi_idx_lsb(SEL_BITS);
  localparam int         WE_BIT     = spi_we_bit(SEL_BITS);

  logic [1:0]           r_state;
  logic [SEL_BITS-1:0]  r_cfg [NUM_XBARS];
  logic [NUM_XBARS-1:0] r_update;
  logic [31:0]          r_wb_dat;
  logic [SEL_BITS-1:0]  r_resp_msg;
  logic                 r_parity;

  logic                 w_wb_req, w_gnt_wb, w_gnt_spi, w_idle;
  logic                 w_we, w_sel_ok;
  logic [SPI_IDX_W-1:0] w_idx;
  logic [SEL_BITS-1:0]  w_wdata, w_rdata, w_resp;
  logic [NUM_XBARS-1:0] w_wen;
  logic                 w_unused_ok;

  assign w_idle   = reset && (r_state == S_IDLE);
  assign w_wb_req = bus.wbs_stb_i && bus.wbs_cyc_i &&
                    (bus.wbs_adr_i[31:8] == ADDR_BASE[31:8]);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_wb  (w_wb_req),
    .req_spi (bus.spi_req_val),
    .en      (w_idle),
    .gnt_wb  (w_gnt_wb),
    .gnt_spi (w_gnt_spi)
  );

  always_comb begin
    w_idx    = w_gnt_wb ? bus.wbs_adr_i[3:2] : bus.spi_req_msg[IDX_LSB +: SPI_IDX_W];
    w_we     = w_gnt_wb ? bus.wbs_we_i : bus.spi_req_msg[WE_BIT];
    w_wdata  = w_gnt_wb ? bus.wbs_dat_i[SEL_BITS-1:0] : bus.spi_req_msg[SPI_DATA_LSB +: SEL_BITS];
    w_sel_ok = w_gnt_wb ? bus.wbs_sel_i[0] : 1'b1;
  end

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < NUM_XBARS; k++) begin
      if (w_idx == SPI_IDX_W'(k)) w_rdata = r_cfg[k];
    end
`ifdef XBAR_CFG_PARITY_EN
    if (NUM_XBARS < 4 && w_idx == 2'd3) w_rdata[SEL_BITS-1] = r_parity;
`endif
  end

  // Override is sampled in the access cycle only
  always_comb begin
    w_wen = '0;
    for (int k = 0; k < NUM_XBARS; k++) begin
      w_wen[k] = (w_gnt_wb || w_gnt_spi) && w_we && w_sel_ok &&
                 (w_idx == SPI_IDX_W'(k)) && !override_i[k];
    end
  end

  // Response carries the post-write value, or the unchanged register on a drop
  assign w_resp = (|w_wen) ? w_wdata : w_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wb_dat   <= '0;
      r_resp_msg <= '0;
      r_update   <= '0;
      r_parity   <= 1'b0;
      for (int k = 0; k < NUM_XBARS; k++) r_cfg[k] <= '0;
    end else begin
      r_update <= '0;
      r_parity <= ^cfg_sel_o;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_wb) begin
            r_state  <= S_WB_ACK;
            r_wb_dat <= 32'(w_resp);
          end else if (w_gnt_spi) begin
            r_state    <= S_SPI_RESP;
            r_resp_msg <= w_resp;
          end
        end
        S_WB_ACK:   r_state <= S_IDLE;
        S_SPI_RESP: if (bus.spi_resp_rdy) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
      for (int k = 0; k < NUM_XBARS; k++) begin
        if (w_wen[k]) begin
          r_cfg[k]    <= w_wdata;
          r_update[k] <= (w_wdata != r_cfg[k]);
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_XBARS; k++) begin : g_pack
    assign cfg_sel_o[k*SEL_BITS +: SEL_BITS] = r_cfg[k];
  end

  assign cfg_update_o     = r_update;
  assign bus.wbs_ack_o    = (r_state == S_WB_ACK);
  assign bus.wbs_dat_o    = r_wb_dat;
  assign bus.spi_req_rdy  = w_gnt_spi;
  assign bus.spi_resp_val = (r_state == S_SPI_RESP);
  assign bus.spi_resp_msg = r_resp_msg;

`ifdef XBAR_CFG_PARITY_EN
  assign cfg_parity_o = r_parity;
  assign w_unused_ok  = ^{bus.wbs_dat_i, bus.wbs_sel_i[3:1], bus.wbs_adr_i[7:4], bus.wbs_adr_i[1:0]};
`else
  assign w_unused_ok  = ^{bus.wbs_dat_i, bus.wbs_sel_i[3:1], bus.wbs_adr_i[7:4], bus.wbs_adr_i[1:0], r_parity};
`endif

endmodule
`default_nettype wire

// File: tb/tb_xbar_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_xbar_cfg_arbiter
// Brief  : Directed stimulus with a queue scoreboard for xbar_cfg_arbiter
// Rev    : 1.0  initial release
// ============================================================================
module tb_xbar_cfg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  override;
  logic [11:0] cfg_sel;
  logic [2:0]  cfg_update;
`ifdef XBAR_CFG_PARITY_EN
  logic        cfg_parity;
`endif

  xbar_cfg_arbiter_if #(.SEL_BITS(4)) bus ();

  xbar_cfg_arbiter #(.NUM_XBARS(3), .SEL_BITS(4), .ADDR_BASE(32'h3000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .override_i   (override),
    .cfg_sel_o    (cfg_sel),
    .cfg_update_o (cfg_update)
`ifdef XBAR_CFG_PARITY_EN
    ,
    .cfg_parity_o (cfg_parity)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] wb_exp[$];
  logic [3:0]  spi_exp[$];
  int          upd_cnt[3];
  int          ack_cnt = 0;
  time         t_wb_ack = 0;
  time         t_spi_resp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response
  always @(negedge clk) begin
    if (bus.wbs_ack_o) begin
      ack_cnt++;
      t_wb_ack = $time;
      if (wb_exp.size() == 0) check("wb_unexpected_ack", 32'd1, 32'd0);
      else check("wb_rdata", bus.wbs_dat_o, wb_exp.pop_front());
    end
    if (bus.spi_resp_val && bus.spi_resp_rdy) begin
      t_spi_resp = $time;
      if (spi_exp.size() == 0) check("spi_unexpected_resp", 32'd1, 32'd0);
      else check("spi_resp", 32'(bus.spi_resp_msg), 32'(spi_exp.pop_front()));
    end
    for (int k = 0; k < 3; k++) if (cfg_update[k]) upd_cnt[k]++;
  end

  task automatic wb_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp, output int lat);
    wb_exp.push_back(exp);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (bus.wbs_ack_o) break;
      if (lat > 50) break;
    end
    if (lat > 50) begin
      check("wb_ack_timeout", 32'(lat), 32'd0);
      void'(wb_exp.pop_back());
    end else begin
      @(posedge clk); #1;
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic spi_txn(input logic we, input logic [1:0] idx, input logic [3:0] data,
                         input logic [3:0] exp);
    int n = 0;
    spi_exp.push_back(exp);
    bus.spi_req_val = 1'b1;
    bus.spi_req_msg = {we, idx, data};
    do begin
      @(negedge clk);
      n++;
    end while (!bus.spi_req_rdy && n < 50);
    if (!bus.spi_req_rdy) begin
      check("spi_rdy_timeout", 32'(n), 32'd0);
      void'(spi_exp.pop_back());
    end
    @(posedge clk); #1;
    bus.spi_req_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int u0, u1;
    int acks;
    reset = 1'b0;
    override = 3'b000;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    bus.spi_req_val = 1'b1; bus.spi_req_msg = 7'b1_00_1111;
    bus.spi_resp_rdy = 1'b1;
    for (int k = 0; k < 3; k++) upd_cnt[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_wb_dat", bus.wbs_dat_o, 32'd0);
    check("rst_req_rdy", 32'(bus.spi_req_rdy), 32'd0);
    check("rst_resp_val", 32'(bus.spi_resp_val), 32'd0);
    check("rst_resp_msg", 32'(bus.spi_resp_msg), 32'd0);
    check("rst_cfg", 32'(cfg_sel), 32'd0);
    check("rst_update", 32'(cfg_update), 32'd0);
    bus.spi_req_val = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: WB write index 1
    u1 = upd_cnt[1];
    wb_txn(1'b1, 32'h3000_0004, 32'h5, 4'h1, 32'h5, lat);
    check("t1_latency", 32'(lat), 32'd1);
    check("t1_cfg", 32'(cfg_sel), 32'h050);
    @(posedge clk); #1;
    check("t1_upd1_pulses", 32'(upd_cnt[1] - u1), 32'd1);

    // 2: SPI write index 2
    spi_txn(1'b1, 2'd2, 4'hA, 4'hA);
    check("t2_resp_val", 32'(bus.spi_resp_val), 32'd1);
    check("t2_cfg", 32'(cfg_sel), 32'hA50);
    @(posedge clk); #1;
    check("t2_resp_done", 32'(bus.spi_resp_val), 32'd0);

    // 3: simultaneous WB read idx2 and SPI read idx0; WB must go first
    t_wb_ack = 0; t_spi_resp = 0;
    fork
      wb_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'hA, lat);
      spi_txn(1'b0, 2'd0, 4'h0, 4'h0);
    join
    @(posedge clk); #1;
    check("t3_wb_first", 32'((t_wb_ack != 0) && (t_wb_ack < t_spi_resp)), 32'd1);

    // 4: override locks index 0
    override = 3'b001;
    u0 = upd_cnt[0];
    wb_txn(1'b1, 32'h3000_0000, 32'h7, 4'h1, 32'h0, lat);
    check("t4_cfg", 32'(cfg_sel), 32'hA50);
    spi_txn(1'b0, 2'd0, 4'h0, 4'h0);
    @(posedge clk); #1;
    check("t4_no_upd0", 32'(upd_cnt[0] - u0), 32'd0);
    override = 3'b000;

    // Boundaries: sel[0]=0 drop, wide data, out-of-range index, same value, bad address
    wb_txn(1'b1, 32'h3000_0000, 32'h3, 4'hE, 32'h0, lat);
    check("sel0_drop_cfg", 32'(cfg_sel), 32'hA50);
    wb_txn(1'b1, 32'h3000_0000, 32'hFFFF_FFF6, 4'h1, 32'h6, lat);
    check("wide_data_cfg", 32'(cfg_sel), 32'hA56);
    spi_txn(1'b1, 2'd3, 4'hF, 4'h0);
    wb_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 32'h0, lat);
    check("idx3_cfg", 32'(cfg_sel), 32'hA56);
    u1 = upd_cnt[1];
    wb_txn(1'b1, 32'h3000_0004, 32'h5, 4'h1, 32'h5, lat);
    @(posedge clk); #1;
    check("same_val_no_upd", 32'(upd_cnt[1] - u1), 32'd0);
    acks = ack_cnt;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'h3000_0104; bus.wbs_dat_i = 32'h9; bus.wbs_sel_i = 4'h1;
    repeat (10) @(posedge clk);
    #1;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    check("bad_adr_no_ack", 32'(ack_cnt - acks), 32'd0);
    check("bad_adr_cfg", 32'(cfg_sel), 32'hA56);

    // 5: SPI response held off while WB waits
    bus.spi_resp_rdy = 1'b0;
    spi_txn(1'b0, 2'd2, 4'h0, 4'hA);
    acks = ack_cnt;
    fork
      wb_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 32'h5, lat);
      begin
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          check("t5_resp_val_held", 32'(bus.spi_resp_val), 32'd1);
          check("t5_resp_msg_stable", 32'(bus.spi_resp_msg), 32'hA);
        end
        check("t5_wb_stalled", 32'(ack_cnt - acks), 32'd0);
        bus.spi_resp_rdy = 1'b1;
      end
    join
    check("t5_wb_after_spi", 32'(t_wb_ack > t_spi_resp), 32'd1);

    // 6: reset during SPI_RESP aborts the response
    bus.spi_resp_rdy = 1'b0;
    spi_txn(1'b1, 2'd1, 4'hC, 4'hC);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_resp_val", 32'(bus.spi_resp_val), 32'd0);
    check("t6_cfg_cleared", 32'(cfg_sel), 32'd0);
    reset = 1'b1;
    spi_exp.delete();
    bus.spi_resp_rdy = 1'b1;
    @(posedge clk); #1;
    wb_txn(1'b1, 32'h3000_0008, 32'h4, 4'h1, 32'h4, lat);
    check("t6_wb_latency", 32'(lat), 32'd1);
    check("t6_cfg", 32'(cfg_sel), 32'h400);

    repeat (3) @(posedge clk);
    #1;
    check("wb_queue_empty", 32'(wb_exp.size()), 32'd0);
    check("spi_queue_empty", 32'(spi_exp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xbar_cfg_arbiter.md
Name: xbar_cfg_arbiter

Overview:
Owns the crossbar select registers for the input, classifier and output crossbars, and shares write/read access to them between two requesters. The requesters are the Caravel Wishbone slave port and the SPI minion's val/rdy stream. A round-robin arbiter serialises the requesters, and per-crossbar override pins lock individual registers against writes. The block sits inside the tape-in interconnect, between the wrapper-level Wishbone/SPI/override pins and the crossbar select inputs.

Parameters:
NUM_XBARS, 3, number of crossbar select registers (legal range 1..4)
SEL_BITS, 4, width of each select register
ADDR_BASE, 32'h3000_0000, Wishbone base address; only adr[31:8] is compared

Ports:
clk  in  1  system clock (wb_clk_i domain)
reset  in  1  synchronous, active-low reset (0 = reset)
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  4  byte selects; byte 0 must be set for a write to take effect
wbs_adr_i  in  32  address; adr[3:2] = register index
wbs_dat_i  in  32  write data; [SEL_BITS-1:0] used
wbs_ack_o  out  1  one-cycle acknowledge
wbs_dat_o  out  32  read data, zero-extended
spi_req_val  in  1  SPI request valid
spi_req_rdy  out  1  SPI request ready
spi_req_msg  in  3+SEL_BITS  bit [SEL_BITS+2] = we; [SEL_BITS+1:SEL_BITS] = index; [SEL_BITS-1:0] = data
spi_resp_val  out  1  SPI response valid
spi_resp_rdy  in  1  SPI response ready
spi_resp_msg  out  SEL_BITS  read value, or the post-write register value
override_i  in  NUM_XBARS  per-crossbar write lock (from the *_xbar_*_override pads, ORed upstream)
cfg_sel_o  out  NUM_XBARS*SEL_BITS  select registers; crossbar k occupies [k*SEL_BITS +: SEL_BITS]
cfg_update_o  out  NUM_XBARS  one-cycle pulse when register k changes

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; all cfg regs=0; wbs_ack_o=0; wbs_dat_o=0; spi_req_rdy=0; spi_resp_val=0; spi_resp_msg=0; cfg_update_o=0; last_grant=SPI, so WB wins the first tie. Reset mid-transaction aborts it. No ack or response is issued for an aborted transaction.
- WB request = stb & cyc & (adr[31:8]==ADDR_BASE[31:8]). Non-matching addresses are ignored and receive no ack.
- SPI request = spi_req_val.
- FSM states: IDLE, WB_ACK, SPI_RESP.
- IDLE:
  - Only WB requesting -> grant WB.
  - Only SPI requesting -> grant SPI.
  - Both requesting -> grant the requester that is not last_grant.
  - Update last_grant on every grant.
- IDLE, WB granted: perform the access this cycle; go to WB_ACK. In WB_ACK, wbs_ack_o=1 for exactly one cycle with registered wbs_dat_o, then return to IDLE. Latency: request sampled at edge N, ack high during cycle N+1.
- IDLE, SPI granted: spi_req_rdy=1 combinationally in that cycle only. On the handshake, perform the access, load spi_resp_msg, and go to SPI_RESP.
- SPI_RESP: hold spi_resp_val=1 and the message stable until spi_resp_rdy=1, then return to IDLE. WB is stalled, with no ack, while in SPI_RESP.
- Write takes effect when: index < NUM_XBARS, override_i[index]==0, and (for WB) sel[0]==1. Otherwise the write is dropped but still acked/responded. The response carries the unchanged register value.
- Read of index >= NUM_XBARS returns 0.
- cfg_update_o[k] pulses the cycle after the register changes. Writing an identical value produces no pulse.
- override_i changing mid-transaction: the value sampled in the access cycle decides.
- No back-to-back grant to the same requester while the other is waiting.

Optional Feature:
XBAR_CFG_PARITY_EN:
- Defined: adds output cfg_parity_o (1 bit) = registered XOR of all cfg_sel_o bits, reset 0, updating one cycle after any register change. Reads at index 3 (when NUM_XBARS<4) return {parity, 0...}.
- Undefined: no port; index 3 reads 0.

Decomposition:
- Package xbar_cfg_pkg holds:
  - state enum {IDLE, WB_ACK, SPI_RESP};
  - requester enum {REQ_WB, REQ_SPI};
  - SPI message field offsets/widths as localparams derived from SEL_BITS;
  - XBAR_IDX_INPUT=0, XBAR_IDX_CLASSIFIER=1, XBAR_IDX_OUTPUT=2.
- One sub-module, rr_arbiter2: two-input round-robin with last_grant register and grant-enable.

Test Plan:
1. Reset, then WB write adr=0x3000_0004, dat=0x5, sel=0x1 -> ack in the next cycle; cfg_sel_o[7:4]=5; cfg_update_o[1] pulses once.
2. SPI write msg {we=1, idx=2, data=0xA} with spi_resp_rdy=1 -> rdy high one cycle; resp_msg=0xA; cfg_sel_o[11:8]=0xA.
3. WB read idx 2 and SPI read idx 0 both asserted in the same cycle after reset -> WB served first; SPI served in the following IDLE; both see correct values.
4. override_i=3'b001, WB write idx 0 dat=0x7 -> acked; register stays 0; no update pulse; SPI read idx 0 returns 0.
5. SPI read with spi_resp_rdy held low for 5 cycles while WB requests -> resp_val stays high with stable msg; WB ack only after the response handshake.
6. reset=0 asserted during SPI_RESP -> resp_val=0 next cycle; all registers cleared; the next WB request is served normally.
